microwave_ctrl_multi: RTL and testbench
=======================================

Name: microwave_ctrl_multi

Overview:
Parametrised next-generation microwave controller: one-hot keypad entry shifted into a BCD mm:ss register, 1 Hz countdown derived from a clock-cycle divider, and start/stop/clear/door interlock FSM. Drives 7-segment outputs and the magnetron enable. Generalises the current controller to N minute digits, any clock rate, pause/resume, two-press stop-clear and a done indication.

Parameters:
CLK_PER_SEC, 100, clock cycles per countdown second (>=10; multiple of 10 when MICROWAVE_POWER_EN is defined)
MIN_DIGITS, 1, number of BCD minute digits (1..3)

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
keypad  in  10  one-hot digit keys, bit k = digit k
startn  in  1  start/resume, active-low
stopn  in  1  pause / clear, active-low
clearn  in  1  clear to 0:00, active-low, highest priority
door_closed  in  1  1 = door closed
sec_ones_segs  out  7  seconds-ones segments, active-high, bit0=a .. bit6=g
sec_tens_segs  out  7  seconds-tens segments
min_segs  out  7*MIN_DIGITS  minute digits, least significant digit in bits [6:0]
mag_on  out  1  magnetron enable
done  out  1  cook complete indicator

Behaviour:
- Reset (async, resetn=0): all digits 0, state IDLE, tick counter 0, mag_on 0, done 0; edge-detect history regs reset to "asserted"/"key down", so inputs held active through reset produce no event.
- Events, synchronous edge-detect, one cycle after the input transition: start = startn 1->0; stop = stopn 1->0; key = keypad goes from 0 to exactly one bit set (multi-bit or no-zero-gap patterns ignored).
- Per-cycle priority: clearn low (level) > door open > stop > start > key.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE: key shifts digits left (ones->tens->min0->...), new digit into ones, top digit discarded. start with nonzero time and door_closed -> RUN, tick counter 0. start with 0:00 or door open: ignored. stop: clear digits.
- RUN: tick counter counts 0..CLK_PER_SEC-1; at terminal count decrement time. Decrement: ones>0 -> ones-1; else tens>0 -> tens-1, ones=9; else minutes BCD-decrement, tens=5, ones=9. Entered tens >5 are legal (0:75 = 75 s). Decrement reaching 0:00 -> DONE in the same cycle. stop or door open -> PAUSE, tick counter held. Keys ignored.
- PAUSE: start with door_closed -> RUN, tick counter resumes from held value. stop -> clear digits, IDLE. Keys ignored.
- DONE: done=1. Any event, clearn low, or door opening -> IDLE, done=0.
- clearn low in any state: digits 0, tick counter 0, IDLE, done 0.
- mag_on = (state==RUN) & door_closed, combinational door gating, so the door opening drops mag_on in the same cycle.
- Segment outputs: combinational decode of registered digits. Pattern 0=0x3F, 1=0x06, ..., 9=0x6F.

Optional Feature:
MICROWAVE_POWER_EN: adds input power_level[3:0]. Values 1..10 are used as-is; 0 or >10 is treated as 10. The value is sampled at each second boundary. In RUN, mag_on is high only while tick counter < power_level*CLK_PER_SEC/10, still gated by door_closed. Without the macro the port is absent and mag_on is full duty.

Decomposition:
Package microwave_pkg: state enum, BCD digit typedef, 7-seg constant table, NUM_KEYS=10.
Sub-module bcd_to_7seg, instantiated 2+MIN_DIGITS times.

Test Plan:
- Keys 6,0,1 (each 0->key->0), then start falling edge: display 6:01, mag_on=1. After 100 cycles 6:00, after 200 cycles 5:59.
- Keys 0,5,5 then start, run to 0:00: DONE after 55*100 cycles, mag_on=0, done=1. Next key press: done=0, IDLE.
- During RUN at 0:30, drop door_closed: mag_on=0 same cycle, PAUSE, time frozen. Close door, then start: resumes at held tick count.
- stop in RUN gives PAUSE. A second stop gives 0:00 in IDLE. Start at 0:00 is ignored (mag_on stays 0).
- clearn low during RUN: 0:00, IDLE, mag_on=0. Async resetn pulse mid-RUN: all outputs 0 immediately. startn held low through reset produces no start event.
- MIN_DIGITS=2, keys 1,2,3,4,5: display 23:45 (first digit discarded). With MICROWAVE_POWER_EN and power_level=3: mag_on high for 30 of each 100 cycles.

Source files
------------

// File: rtl/microwave_pkg.sv
// microwave_pkg: shared state type, BCD digit type, key count and 7-segment table
package microwave_pkg;
  localparam int NUM_KEYS = 10;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  typedef logic [3:0] bcd_t;
  localparam logic [69:0] SEG_TABLE = {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                       7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: active-high a..g decode of one BCD digit, blank for non-decimal codes
module bcd_to_7seg
  import microwave_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] segs
);
  // table lookup, out-of-range codes blank the digit
  always_comb segs = (digit < 4'd10) ? SEG_TABLE[7*int'(digit) +: 7] : 7'h00;
endmodule

// File: rtl/microwave_ctrl_multi.sv
// microwave_ctrl_multi: keypad BCD timer, 1 Hz countdown and door interlock; MICROWAVE_POWER_EN adds duty-cycled power
module microwave_ctrl_multi
  import microwave_pkg::*;
#(
  parameter int CLK_PER_SEC = 100,
  parameter int MIN_DIGITS = 1
) (
  input  logic clock,
  input  logic resetn,
  input  logic [NUM_KEYS-1:0] keypad,
  input  logic startn,
  input  logic stopn,
  input  logic clearn,
  input  logic door_closed,
`ifdef MICROWAVE_POWER_EN
  input  logic [3:0] power_level,
`endif
  output logic [6:0] sec_ones_segs,
  output logic [6:0] sec_tens_segs,
  output logic [7*MIN_DIGITS-1:0] min_segs,
  output logic mag_on,
  output logic done
);
  localparam int ND = MIN_DIGITS + 2;
  localparam int TW = $clog2(CLK_PER_SEC);
  state_t st, st_n;
  logic [4*ND-1:0] t, t_n, t_dec;
  logic [TW-1:0] tick, tick_n;
  logic [NUM_KEYS-1:0] kp_q;
  logic start_q, stop_q, borrow, ev_start, ev_stop, ev_key, sec_end;
  bcd_t key_d;
  assign ev_start = start_q & ~startn;
  assign ev_stop = stop_q & ~stopn;
  assign ev_key = (kp_q == '0) && $onehot(keypad);
  assign sec_end = tick == TW'(CLK_PER_SEC - 1);
  assign done = st == DONE;
  // index of the pressed key
  always_comb begin
    key_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) if (keypad[i]) key_d = i[3:0];
  end
  // one-second BCD decrement; seconds-tens wraps to 5, every other digit to 9
  always_comb begin
    t_dec = t;
    borrow = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (borrow && t[4*i +: 4] == 4'd0) t_dec[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
      else if (borrow) begin
        t_dec[4*i +: 4] = t[4*i +: 4] - 4'd1;
        borrow = 1'b0;
      end
    end
  end
  // control FSM: clear beats door beats stop beats start beats key
  always_comb begin
    st_n = st;
    t_n = t;
    tick_n = tick;
    if (!clearn) begin
      st_n = IDLE;
      t_n = '0;
      tick_n = '0;
    end else case (st)
      IDLE: if (door_closed) begin
        if (ev_stop) t_n = '0;
        else if (ev_start) begin
          st_n = (t != '0) ? RUN : IDLE;
          tick_n = '0;
        end else if (ev_key) t_n = {t[4*ND-5:0], key_d};
      end
      RUN: if (!door_closed || ev_stop) st_n = PAUSE;
        else if (sec_end) begin
          tick_n = '0;
          t_n = t_dec;
          st_n = (t_dec == '0) ? DONE : RUN;
        end else tick_n = tick + TW'(1);
      PAUSE: if (door_closed) begin
        if (ev_stop) begin
          st_n = IDLE;
          t_n = '0;
        end else if (ev_start) st_n = RUN;
      end
      default: st_n = (!door_closed || ev_stop || ev_start || ev_key) ? IDLE : DONE;
    endcase
  end
  // state, time, tick and edge history; history resets to the asserted level so held inputs are not events
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      st <= IDLE;
      t <= '0;
      tick <= '0;
      kp_q <= '1;
      start_q <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      st <= st_n;
      t <= t_n;
      tick <= tick_n;
      kp_q <= keypad;
      start_q <= startn;
      stop_q <= stopn;
    end
`ifdef MICROWAVE_POWER_EN
  logic [3:0] pw_q;
  // power level latched at second boundaries; tracks the input while not cooking
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) pw_q <= 4'd10;
    else if (st != RUN || sec_end) pw_q <= (power_level == 4'd0 || power_level > 4'd10) ? 4'd10 : power_level;
  assign mag_on = (st == RUN) && door_closed && (int'(tick) < int'(pw_q) * (CLK_PER_SEC / 10));
`else
  assign mag_on = (st == RUN) && door_closed;
`endif
  bcd_to_7seg u_ones (.digit(t[3:0]), .segs(sec_ones_segs));
  bcd_to_7seg u_tens (.digit(t[7:4]), .segs(sec_tens_segs));
  for (genvar m = 0; m < MIN_DIGITS; m++) begin : g_min
    bcd_to_7seg u_min (.digit(t[8+4*m +: 4]), .segs(min_segs[7*m +: 7]));
  end
endmodule

// File: tb/tb_microwave_ctrl_multi.sv
// tb_microwave_ctrl_multi: directed and random stimulus against a digit-level reference model
module tb_microwave_ctrl_multi;
  localparam int CPS = 100;
  localparam int MD = 2;
  localparam int ND = MD + 2;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
  logic clock = 1'b0, resetn = 1'b0;
  logic [9:0] keypad = '0;
  logic startn = 1'b1, stopn = 1'b1, clearn = 1'b1, door_closed = 1'b1;
  logic [6:0] sec_ones_segs, sec_tens_segs;
  logic [7*MD-1:0] min_segs;
  logic mag_on, done;
  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int n_cmp = 0, n_bad = 0;
  int m_dig [ND];
  int m_st, m_tick;
  bit p_startn, p_stopn;
  logic [9:0] p_kp;
  logic [31:0] disp;
  int n;
`ifdef MICROWAVE_POWER_EN
  logic [3:0] power_level = 4'd3;
`endif

  microwave_ctrl_multi #(.CLK_PER_SEC(CPS), .MIN_DIGITS(MD)) dut (
    .clock(clock), .resetn(resetn), .keypad(keypad), .startn(startn), .stopn(stopn),
    .clearn(clearn), .door_closed(door_closed),
`ifdef MICROWAVE_POWER_EN
    .power_level(power_level),
`endif
    .sec_ones_segs(sec_ones_segs), .sec_tens_segs(sec_tens_segs), .min_segs(min_segs),
    .mag_on(mag_on), .done(done));

  always #5 clock = ~clock;
  assign disp = 32'({min_segs, sec_tens_segs, sec_ones_segs});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] disp_of(input int d [ND]);
    logic [31:0] v = '0;
    for (int k = 0; k < ND; k++) v[7*k +: 7] = segtab[d[k]];
    return v;
  endfunction

  function automatic logic exp_mag();
`ifdef MICROWAVE_POWER_EN
    return m_st == S_RUN && door_closed && m_tick < 3 * CPS / 10;
`else
    return m_st == S_RUN && door_closed;
`endif
  endfunction

  function automatic bit is_zero();
    int s = 0;
    for (int k = 0; k < ND; k++) s += m_dig[k];
    return s == 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ND; k++) m_dig[k] = 0;
    m_st = S_IDLE;
    m_tick = 0;
    p_startn = 1'b0;
    p_stopn = 1'b0;
    p_kp = '1;
  endtask

  task automatic model_dec();
    int mins = 0;
    if (m_dig[0] > 0) m_dig[0]--;
    else if (m_dig[1] > 0) begin
      m_dig[1]--;
      m_dig[0] = 9;
    end else begin
      for (int k = ND - 1; k >= 2; k--) mins = mins * 10 + m_dig[k];
      mins--;
      for (int k = 2; k < ND; k++) begin
        m_dig[k] = mins % 10;
        mins /= 10;
      end
      m_dig[1] = 5;
      m_dig[0] = 9;
    end
  endtask

  task automatic model_step();
    bit es, ep, ek;
    int kd = 0;
    if (!resetn) begin
      model_reset();
      return;
    end
    es = p_startn && !startn;
    ep = p_stopn && !stopn;
    ek = (p_kp == '0) && ($countones(keypad) == 1);
    for (int i = 0; i < 10; i++) if (keypad[i]) kd = i;
    p_startn = startn;
    p_stopn = stopn;
    p_kp = keypad;
    if (!clearn) begin
      for (int k = 0; k < ND; k++) m_dig[k] = 0;
      m_tick = 0;
      m_st = S_IDLE;
    end else if (!door_closed) begin
      if (m_st == S_RUN) m_st = S_PAUSE;
      else if (m_st == S_DONE) m_st = S_IDLE;
    end else if (m_st == S_DONE) begin
      if (es || ep || ek) m_st = S_IDLE;
    end else if (ep) begin
      if (m_st == S_RUN) m_st = S_PAUSE;
      else begin
        for (int k = 0; k < ND; k++) m_dig[k] = 0;
        m_st = S_IDLE;
      end
    end else if (m_st == S_RUN) begin
      if (m_tick == CPS - 1) begin
        m_tick = 0;
        model_dec();
        if (is_zero()) m_st = S_DONE;
      end else m_tick++;
    end else if (es) begin
      if (m_st == S_PAUSE) m_st = S_RUN;
      else if (!is_zero()) begin
        m_st = S_RUN;
        m_tick = 0;
      end
    end else if (ek && m_st == S_IDLE) begin
      for (int k = ND - 1; k > 0; k--) m_dig[k] = m_dig[k-1];
      m_dig[0] = kd;
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
    chk("disp", disp, disp_of(m_dig));
    chk("mag_on", 32'(mag_on), 32'(exp_mag()));
    chk("done", 32'(done), 32'(m_st == S_DONE));
    @(negedge clock);
  endtask

  task automatic run(input int c);
    for (int i = 0; i < c; i++) cyc();
  endtask

  task automatic key(input int k);
    keypad = 10'(1) << k;
    run(2);
    keypad = '0;
    run(2);
  endtask

  task automatic start_p();
    startn = 1'b0;
    cyc();
    startn = 1'b1;
    cyc();
  endtask

  task automatic stop_p();
    stopn = 1'b0;
    cyc();
    stopn = 1'b1;
    cyc();
  endtask

  initial begin
    int zero_d [ND] = '{default: 0};
    int d601 [ND] = '{1, 0, 6, 0};
    int d600 [ND] = '{0, 0, 6, 0};
    int d559 [ND] = '{9, 5, 5, 0};
    int d055 [ND] = '{5, 5, 0, 0};
    int d2345 [ND] = '{5, 4, 3, 2};
    model_reset();
    keypad = 10'(1) << 7;
    startn = 1'b0;
    @(negedge clock);
    #1;
    chk("reset_disp", disp, disp_of(zero_d));
    chk("reset_mag", 32'(mag_on), 0);
    chk("reset_done", 32'(done), 0);
    run(3);
    resetn = 1'b1;
    run(3);
    keypad = '0;
    startn = 1'b1;
    run(3);
    chk("held_inputs", disp, disp_of(zero_d));
    key(6); key(0); key(1);
    chk("entry_601", disp, disp_of(d601));
    start_p();
    chk("start_mag", 32'(mag_on), 1);
    run(CPS - 1);
    chk("tick_600", disp, disp_of(d600));
    run(CPS);
    chk("tick_559", disp, disp_of(d559));
    clearn = 1'b0;
    cyc();
    clearn = 1'b1;
    cyc();
    chk("clear_disp", disp, disp_of(zero_d));
    chk("clear_mag", 32'(mag_on), 0);
    key(0); key(5); key(5);
    chk("entry_055", disp, disp_of(d055));
    startn = 1'b0;
    cyc();
    startn = 1'b1;
    n = 0;
    while (!done && n < 60 * CPS) begin
      cyc();
      n++;
    end
    chk("done_cycles", n, 55 * CPS);
    chk("done_flag", 32'(done), 1);
    chk("done_mag", 32'(mag_on), 0);
    key(3);
    chk("done_cleared", 32'(done), 0);
    stop_p();
    key(3); key(5);
    start_p();
    run(5 * CPS + 35);
    door_closed = 1'b0;
    #1;
    chk("door_mag", 32'(mag_on), 0);
    run(20);
    door_closed = 1'b1;
    run(5);
    start_p();
    run(3 * CPS);
    stop_p();
    chk("stop_pause_mag", 32'(mag_on), 0);
    stop_p();
    chk("stop2_disp", disp, disp_of(zero_d));
    start_p();
    chk("start_zero_mag", 32'(mag_on), 0);
    key(1); key(2); key(3); key(4); key(5);
    chk("entry_2345", disp, disp_of(d2345));
    start_p();
    run(150);
    startn = 1'b0;
    resetn = 1'b0;
    #1;
    model_reset();
    chk("async_disp", disp, disp_of(zero_d));
    chk("async_mag", 32'(mag_on), 0);
    run(3);
    resetn = 1'b1;
    run(3);
    startn = 1'b1;
    run(3);
    chk("async_idle_mag", 32'(mag_on), 0);
    key(9); key(0);
    for (int i = 0; i < 8000; i++) begin
      int r = $urandom_range(0, 999);
      int rk = $urandom_range(0, 99);
      startn = (r < 40) ? 1'b0 : 1'b1;
      stopn = (r >= 990) ? 1'b0 : 1'b1;
      clearn = (r == 500) ? 1'b0 : 1'b1;
      if (r >= 980 && r < 990) door_closed = ~door_closed;
      keypad = (rk < 8) ? 10'(1) << $urandom_range(0, 9) : (rk < 10) ? 10'($urandom_range(0, 1023)) : '0;
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
